// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the decode input of the pipeline core.
// Owns the PC, issues one instruction-memory request at a time, and presents
// {instruction, PC} to decode through a registered valid/ready output backed
// by a one-entry skid buffer. Branch redirects from execute and PC loads via
// pcSelect squash anything in flight.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   pcSelect         load PC from startAddress and hold fetch
//   startAddress     PC load value
//   branchTaken      redirect request from execute
//   branchTarget     redirect PC
//   imemReqValid     fetch request valid        (to instruction memory)
//   imemReqReady     memory accepts request     (from instruction memory)
//   imemAddr         fetch address
//   imemRespValid    response valid, one per accepted request
//   imemRespData     fetched instruction
//   ifValid          decode output valid
//   idReady          decode accepts output
//   ifInstr, ifPc    instruction and its PC
//   ifPcPlus4        ifPc + PC_INCR
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    PC_INCR    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcSelect,
    input  logic [ADDR_WIDTH-1:0] startAddress,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic                  imemReqValid,
    input  logic                  imemReqReady,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemRespValid,
    input  logic [DATA_WIDTH-1:0] imemRespData,
    output logic                  ifValid,
    input  logic                  idReady,
    output logic [DATA_WIDTH-1:0] ifInstr,
    output logic [ADDR_WIDTH-1:0] ifPc,
    output logic [ADDR_WIDTH-1:0] ifPcPlus4
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCR);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetchState_e;

    fetchState_e           state;
    fetchState_e           stateNext;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic [ADDR_WIDTH-1:0] reqPc;
    logic [DATA_WIDTH-1:0] skidInstr;
    logic [ADDR_WIDTH-1:0] skidPc;

    logic reqFire;
    logic slotFree;
    logic latchReq;
    logic loadResp;
    logic loadSkid;
    logic storeSkid;
    logic squashOut;

    // PC only changes outside REQ, so the address is stable under valid.
    assign imemAddr  = pc;
    assign ifPcPlus4 = ifPc + PC_STEP;

    // ---------------------------------------------------------------------
    // Next-state / control decode
    // ---------------------------------------------------------------------
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        latchReq     = 1'b0;
        loadResp     = 1'b0;
        loadSkid     = 1'b0;
        storeSkid    = 1'b0;
        squashOut    = 1'b0;
        imemReqValid = (state == REQ) && !pcSelect;
        reqFire      = imemReqValid && imemReqReady;
        slotFree     = !ifValid || idReady;

        if (pcSelect) begin
            pcNext    = startAddress;
            squashOut = 1'b1;
            // A response landing this very cycle retires the outstanding
            // request, so there is nothing left to drop.
            if ((state == WAIT || state == DROP) && !imemRespValid) begin
                stateNext = DROP;
            end else begin
                stateNext = IDLE;
            end
        end else if (branchTaken) begin
            pcNext    = branchTarget;
            squashOut = 1'b1;
            unique case (state)
                IDLE:    stateNext = IDLE;
                // Unaccepted request is withdrawn via IDLE so imemAddr never
                // changes while valid is high.
                REQ:     stateNext = reqFire ? DROP : IDLE;
                WAIT:    stateNext = imemRespValid ? REQ : DROP;
                HOLD:    stateNext = REQ;
                // A response arriving now is the one being dropped.
                DROP:    stateNext = imemRespValid ? REQ : DROP;
                default: stateNext = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: stateNext = REQ;
                REQ: begin
                    if (reqFire) begin
                        latchReq  = 1'b1;
                        stateNext = WAIT;
                    end
                end
                WAIT: begin
                    if (imemRespValid) begin
                        if (slotFree) begin
                            loadResp  = 1'b1;
                            pcNext    = reqPc + PC_STEP;
                            stateNext = REQ;
                        end else begin
                            storeSkid = 1'b1;
                            stateNext = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (idReady) begin
                        loadSkid  = 1'b1;
                        pcNext    = pc + PC_STEP;
                        stateNext = REQ;
                    end
                end
                DROP: begin
                    if (imemRespValid) begin
                        stateNext = REQ;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // State and PC registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_ADDR;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    // Request PC and skid entry are pure data; skid occupancy is the HOLD
    // state itself, so leaving HOLD empties it.
    always_ff @(posedge clk) begin
        if (latchReq) begin
            reqPc <= pc;
        end
        if (storeSkid) begin
            skidInstr <= imemRespData;
            skidPc    <= reqPc;
        end
    end

    // ---------------------------------------------------------------------
    // Decode output register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ifValid <= 1'b0;
            ifInstr <= '0;
            ifPc    <= '0;
        end else if (squashOut) begin
            ifValid <= 1'b0;
        end else if (loadResp) begin
            ifValid <= 1'b1;
            ifInstr <= imemRespData;
            ifPc    <= reqPc;
        end else if (loadSkid) begin
            ifValid <= 1'b1;
            ifInstr <= skidInstr;
            ifPc    <= skidPc;
        end else if (idReady) begin
            ifValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small instruction-memory responder inside
// the tick task returns addr ^ 0xA5A5A5A5 a configurable number of cycles
// after each accepted request.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] MASK = 32'hA5A5A5A5;

    logic        clk;
    logic        reset;
    logic        pcSelect;
    logic [31:0] startAddress;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        ifValid;
    logic        idReady;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic [31:0] ifPcPlus4;

    int          nChecks = 0;
    int          nFail   = 0;

    logic        pend;
    logic [31:0] pendAddr;
    int          wt;
    int          memLatency;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_ADDR (32'h0000_0000),
        .PC_INCR    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pcSelect      (pcSelect),
        .startAddress  (startAddress),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemAddr      (imemAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .ifValid       (ifValid),
        .idReady       (idReady),
        .ifInstr       (ifInstr),
        .ifPc          (ifPc),
        .ifPcPlus4     (ifPcPlus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: capture handshake before the edge, then update the memory
    // model and let outputs settle before the caller samples them.
    task automatic tick();
        logic        acc;
        logic [31:0] addr;
        acc  = imemReqValid && imemReqReady;
        addr = imemAddr;
        @(posedge clk);
        #1;
        imemRespValid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (acc) begin
                pend     = 1'b1;
                pendAddr = addr;
                wt       = memLatency - 1;
            end else if (pend && wt > 0) begin
                wt--;
            end
            if (pend && wt == 0) begin
                imemRespValid = 1'b1;
                imemRespData  = pendAddr ^ MASK;
                pend          = 1'b0;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        pcSelect      = 1'b0;
        startAddress  = 32'h0;
        branchTaken   = 1'b0;
        branchTarget  = 32'h0;
        imemReqReady  = 1'b1;
        imemRespValid = 1'b0;
        imemRespData  = 32'h0;
        idReady       = 1'b1;
        pend          = 1'b0;
        pendAddr      = 32'h0;
        wt            = 0;
        memLatency    = 1;

        // ---- reset state
        tick();
        tick();
        check("rst_ifValid", {31'b0, ifValid}, 32'd0);
        check("rst_reqValid", {31'b0, imemReqValid}, 32'd0);
        check("rst_imemAddr", imemAddr, 32'h0);
        check("rst_ifPc", ifPc, 32'h0);
        check("rst_ifInstr", ifInstr, 32'h0);

        // ---- test 1: streaming with zero-wait memory
        reset        = 1'b0;
        pcSelect     = 1'b1;
        startAddress = 32'h0000_1000;
        tick();
        check("t1_selHoldReq", {31'b0, imemReqValid}, 32'd0);
        tick();
        check("t1_selAddr", imemAddr, 32'h1000);
        pcSelect = 1'b0;
        tick();
        check("t1_req0_valid", {31'b0, imemReqValid}, 32'd1);
        check("t1_req0_addr", imemAddr, 32'h1000);
        tick();
        check("t1_wait_noReq", {31'b0, imemReqValid}, 32'd0);
        check("t1_wait_ifValid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t1_out0_valid", {31'b0, ifValid}, 32'd1);
        check("t1_out0_pc", ifPc, 32'h1000);
        check("t1_out0_instr", ifInstr, 32'hA5A5B5A5);
        check("t1_out0_plus4", ifPcPlus4, 32'h1004);
        check("t1_req1_addr", imemAddr, 32'h1004);
        tick();
        check("t1_gap_ifValid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t1_out1_valid", {31'b0, ifValid}, 32'd1);
        check("t1_out1_pc", ifPc, 32'h1004);
        check("t1_out1_instr", ifInstr, 32'h1004 ^ MASK);
        check("t1_req2_addr", imemAddr, 32'h1008);

        // ---- test 2: decode stall, skid buffer
        pcSelect     = 1'b1;
        startAddress = 32'h0000_1000;
        tick();
        check("t2_sel_ifValid", {31'b0, ifValid}, 32'd0);
        pcSelect = 1'b0;
        tick();
        tick();
        tick();
        check("t2_out0_pc", ifPc, 32'h1000);
        idReady = 1'b0;
        tick();
        check("t2_stall1_valid", {31'b0, ifValid}, 32'd1);
        check("t2_stall1_pc", ifPc, 32'h1000);
        tick();
        check("t2_hold_noReq", {31'b0, imemReqValid}, 32'd0);
        check("t2_hold_pc", ifPc, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_holdN_noReq", {31'b0, imemReqValid}, 32'd0);
            check("t2_holdN_instr", ifInstr, 32'h1000 ^ MASK);
            check("t2_holdN_valid", {31'b0, ifValid}, 32'd1);
        end
        idReady = 1'b1;
        tick();
        check("t2_rel_valid", {31'b0, ifValid}, 32'd1);
        check("t2_rel_pc", ifPc, 32'h1004);
        check("t2_rel_instr", ifInstr, 32'h1004 ^ MASK);
        check("t2_rel_reqAddr", imemAddr, 32'h1008);
        check("t2_rel_reqValid", {31'b0, imemReqValid}, 32'd1);
        tick();
        check("t2_gap_valid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t2_next_pc", ifPc, 32'h1008);
        check("t2_next_valid", {31'b0, ifValid}, 32'd1);

        // ---- test 3: branch while waiting on 0x1004 (response same cycle)
        pcSelect     = 1'b1;
        startAddress = 32'h0000_1000;
        tick();
        pcSelect = 1'b0;
        tick();
        tick();
        tick();
        check("t3_out0_pc", ifPc, 32'h1000);
        tick();
        check("t3_wait_resp", {31'b0, imemRespValid}, 32'd1);
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_2000;
        tick();
        branchTaken = 1'b0;
        check("t3_br_ifValid", {31'b0, ifValid}, 32'd0);
        check("t3_br_addr", imemAddr, 32'h2000);
        check("t3_br_reqValid", {31'b0, imemReqValid}, 32'd1);
        tick();
        check("t3_br_wait_ifValid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t3_tgt_pc", ifPc, 32'h2000);
        check("t3_tgt_instr", ifInstr, 32'hA5A585A5);

        // ---- test 3b: branch while waiting, response still in flight
        memLatency = 2;
        tick();
        check("t3b_wait_noResp", {31'b0, imemRespValid}, 32'd0);
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_3000;
        tick();
        branchTaken = 1'b0;
        check("t3b_drop_noReq", {31'b0, imemReqValid}, 32'd0);
        check("t3b_drop_ifValid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t3b_req_valid", {31'b0, imemReqValid}, 32'd1);
        check("t3b_req_addr", imemAddr, 32'h3000);
        check("t3b_noStale", {31'b0, ifValid}, 32'd0);
        memLatency = 1;
        tick();
        tick();
        check("t3b_out_pc", ifPc, 32'h3000);
        check("t3b_out_instr", ifInstr, 32'h3000 ^ MASK);

        // ---- test 4: memory back-pressure at 0x1000
        imemReqReady = 1'b0;
        pcSelect     = 1'b1;
        startAddress = 32'h0000_1000;
        tick();
        pcSelect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_valid", {31'b0, imemReqValid}, 32'd1);
            check("t4_stall_addr", imemAddr, 32'h1000);
        end
        imemReqReady = 1'b1;
        tick();
        check("t4_wait_noReq", {31'b0, imemReqValid}, 32'd0);
        check("t4_wait_ifValid", {31'b0, ifValid}, 32'd0);
        tick();
        check("t4_out_valid", {31'b0, ifValid}, 32'd1);
        check("t4_out_pc", ifPc, 32'h1000);

        // ---- test 5: reset during WAIT with ifValid high
        idReady = 1'b0;
        tick();
        check("t5_pre_valid", {31'b0, ifValid}, 32'd1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        idReady = 1'b1;
        check("t5_rst_ifValid", {31'b0, ifValid}, 32'd0);
        check("t5_rst_reqValid", {31'b0, imemReqValid}, 32'd0);
        check("t5_rst_pc", imemAddr, 32'h0);
        tick();
        check("t5_req_valid", {31'b0, imemReqValid}, 32'd1);
        check("t5_req_addr", imemAddr, 32'h0);
        tick();
        tick();
        check("t5_out_pc", ifPc, 32'h0);
        check("t5_out_instr", ifInstr, 32'hA5A5A5A5);
        check("t5_out_plus4", ifPcPlus4, 32'h4);

        // ---- test 6: PC wrap-around
        pcSelect     = 1'b1;
        startAddress = 32'hFFFF_FFFC;
        tick();
        pcSelect = 1'b0;
        tick();
        check("t6_req_addr", imemAddr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("t6_out_pc", ifPc, 32'hFFFF_FFFC);
        check("t6_out_plus4", ifPcPlus4, 32'h0);
        check("t6_out_instr", ifInstr, 32'h5A5A_5A59);
        check("t6_wrap_addr", imemAddr, 32'h0);
        tick();
        tick();
        check("t6_wrap_pc", ifPc, 32'h0);
        check("t6_wrap_valid", {31'b0, ifValid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of the pipeline core's decode input. It owns the PC and loads it from startAddress while pcSelect is high. It fetches from instruction memory over a valid/ready request and response handshake, with one request outstanding at most. It presents {instruction, PC} to decode through a registered valid/ready output with a one-entry skid buffer, and honours branch redirects from execute.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
DATA_WIDTH, 32, instruction width
RESET_ADDR, 32'h0000_0000, PC value after reset
PC_INCR, 4, PC increment per instruction

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
pcSelect  in  1  high: load PC from startAddress and hold fetch
startAddress  in  ADDR_WIDTH  PC load value
branchTaken  in  1  redirect request from execute
branchTarget  in  ADDR_WIDTH  redirect PC
imemReqValid  out  1  fetch request valid
imemReqReady  in  1  memory accepts request
imemAddr  out  ADDR_WIDTH  fetch address
imemRespValid  in  1  response valid (exactly one per accepted request)
imemRespData  in  DATA_WIDTH  fetched instruction
ifValid  out  1  decode output valid
idReady  in  1  decode accepts output
ifInstr  out  DATA_WIDTH  instruction to decode
ifPc  out  ADDR_WIDTH  PC of ifInstr
ifPcPlus4  out  ADDR_WIDTH  ifPc + PC_INCR, combinational from ifPc register

Behaviour:
- Priority, highest first: reset > pcSelect > branchTaken > normal operation.
- Reset values:
  - pc=RESET_ADDR, state=IDLE
  - ifValid=0, ifInstr=0, ifPc=0, skid empty
  - imemReqValid=0, imemAddr=RESET_ADDR
- Instruction memory shares reset, so no response is pending after reset. imemRespValid in IDLE or REQ is ignored.
- pcSelect=1:
  - pc<=startAddress, ifValid<=0, skid cleared.
  - Next state is IDLE, or DROP if a request is outstanding (WAIT, or REQ accepted this cycle).
  - imemReqValid=0 while pcSelect=1.
- States: IDLE, REQ, WAIT, HOLD, DROP.
  - IDLE: imemReqValid=0; if pcSelect=0, go to REQ next cycle.
  - REQ: imemReqValid=1, imemAddr=pc. imemAddr stays stable while valid and not ready. On imemReqReady, latch reqPc=pc and go to WAIT.
  - WAIT: on imemRespValid:
    - If the output slot is free (ifValid=0, or ifValid&&idReady this cycle): load ifInstr=data, ifPc=reqPc, ifValid=1, pc<=reqPc+PC_INCR, go to REQ.
    - Otherwise: store data and reqPc in skid, go to HOLD.
  - HOLD: imemReqValid=0. When idReady, move skid to output (ifValid stays 1), pc<=pc+PC_INCR, go to REQ.
  - DROP: wait for imemRespValid, discard it, go to REQ (IDLE if pcSelect=1).
- Output handshake: transfer when ifValid&&idReady. ifValid falls the following cycle unless new data loads in the same cycle. Output registers hold while ifValid&&!idReady.
- branchTaken=1 (pcSelect=0): pc<=branchTarget, ifValid<=0 regardless of idReady, skid cleared. Per state:
  - REQ not accepted: go to IDLE. This gives one bubble, so imemAddr never changes under valid.
  - REQ accepted this cycle: go to DROP.
  - WAIT with no response this cycle: go to DROP.
  - WAIT with response this cycle: discard it, go to REQ.
  - HOLD: go to REQ.
  - IDLE: stay IDLE (REQ next cycle).
  - DROP: stay DROP.
- Arithmetic: all PC adds are modulo 2^ADDR_WIDTH (0xFFFFFFFC+4=0x00000000). No alignment checking.
- Throughput: with zero-wait memory (ready=1, response the cycle after acceptance), one instruction per 2 cycles. Latency from REQ acceptance to ifValid is 2 cycles.

Test Plan:
1. Reset, pcSelect=1 with startAddress=0x00001000 for 2 cycles, then 0; zero-wait memory returning data=addr^0xA5A5A5A5; idReady=1 -> imemAddr sequence 0x1000, 0x1004, 0x1008; ifPc matches; ifInstr=0xA5A5B5A5 for 0x1000; ifPcPlus4=0x1004 for 0x1000; ifValid pulses every 2 cycles.
2. idReady=0 for 6 cycles mid-stream -> ifInstr/ifPc held; one response lands in skid; no new imemReqValid during HOLD; after release, 0x1004 then 0x1008 delivered in order, none lost or duplicated.
3. branchTaken with branchTarget=0x00002000 while in WAIT for 0x1004 -> response for 0x1004 discarded; next imemAddr=0x2000; ifPc=0x1004 never presented; ifValid=0 the cycle after redirect.
4. imemReqReady=0 for 3 cycles at address 0x1000 -> imemReqValid=1 and imemAddr=0x1000 stable for all 3 cycles; single WAIT after acceptance.
5. reset asserted for 1 cycle during WAIT with ifValid=1 -> next cycle ifValid=0, imemReqValid=0, pc=RESET_ADDR; fetch resumes at 0x00000000 if pcSelect=0.
6. startAddress=0xFFFFFFFC -> first fetch 0xFFFFFFFC with ifPcPlus4=0x00000000; second fetch imemAddr=0x00000000.
